div_unit: RTL and testbench
===========================

# div_unit

Sequential signed 32-bit divider consuming the control unit's `div_control` start pulse and the A/B register operands, and producing `div_stop` / `div_zero` back to the control unit plus quotient/remainder for the HI/LO registers. It uses a restoring shift-subtract algorithm on operand magnitudes, one quotient bit per cycle, followed by a sign-fix cycle. Results follow MIPS `div` semantics:
- quotient truncated toward zero;
- remainder takes the sign of the dividend.

## Interface
- `WIDTH`, 32, operand/result width; iteration counter is `$clog2(WIDTH)+1` bits.

- `clk`  in  1  clock, all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `div_control`  in  1  start request, sampled only in IDLE.
- `a`  in  WIDTH  dividend (two's complement), captured at start.
- `b`  in  WIDTH  divisor (two's complement), captured at start.
- `lo_out`  out  WIDTH  quotient, registered, held until next successful division.
- `hi_out`  out  WIDTH  remainder, registered, held until next successful division.
- `div_stop`  out  1  one-cycle pulse: operation finished (normal or divide-by-zero).
- `div_zero`  out  1  one-cycle pulse coincident with `div_stop` when divisor was zero.
- `busy`  out  1  high in CALC and FIX.

## Operation
- Reset (synchronous): state IDLE, counter 0. All outputs are 0: `lo_out`, `hi_out`, `div_stop`, `div_zero`, `busy`.
- Internal registers:
  - `rem` (WIDTH+1 bits);
  - `quo` (WIDTH);
  - `dvs` (WIDTH);
  - `neg_q` = sign(a) XOR sign(b);
  - `neg_r` = sign(a).
- IDLE:
  - With `div_control`=1 and `b`≠0: capture |a| into `quo`, |b| into `dvs`, clear `rem`, record `neg_q`/`neg_r`, counter←0, go to CALC.
  - With `div_control`=1 and `b`=0: stay IDLE, pulse `div_stop` and `div_zero` next cycle. `lo_out`/`hi_out` unchanged.
- Magnitudes are unsigned WIDTH-bit. |0x80000000| = 0x80000000, with no overflow.
- CALC, once per cycle:
  - shift {rem,quo} left 1;
  - trial = rem − dvs;
  - if trial ≥ 0 then rem←trial and quo[0]←1, else quo[0]←0;
  - counter+1.
  - After the WIDTH-th iteration go to FIX.
- FIX:
  - `lo_out` ← neg_q ? −quo : quo;
  - `hi_out` ← neg_r ? −rem[WIDTH-1:0] : rem[WIDTH-1:0];
  - `div_stop`←1;
  - go to IDLE.
- `div_stop`/`div_zero` are cleared on the following edge unless re-asserted.
- `div_control` is ignored while `busy`=1. No queuing.
- 0x80000000 / 0xFFFFFFFF gives `lo_out`=0x80000000, `hi_out`=0. No trap; wrap is the defined result.
- Reset mid-operation aborts immediately and takes the reset values; no `div_stop` is produced.

## Timing
- Start accepted at edge N (IDLE, `div_control`=1, `b`≠0):
  - `busy`=1 from after edge N through after edge N+WIDTH+1 inclusive.
  - CALC occupies edges N+1..N+WIDTH; FIX is evaluated at edge N+WIDTH+1.
  - `lo_out`/`hi_out` update and `div_stop`=1 after edge N+WIDTH+1, i.e. 33 cycles after start for WIDTH=32.
  - `busy`=0 and `div_stop`=0 after edge N+WIDTH+2.
  - A new start is accepted at edge N+WIDTH+2 at the earliest (back-to-back permitted).
- Divide-by-zero at edge N: `div_stop`=`div_zero`=1 after edge N, cleared after N+1. `busy` stays 0.
- Operands may change after the start edge without affecting the result.
- Reset has priority over start at the same edge.

## Test plan
- Unsigned 7/2 → after 33 cycles `lo_out`=3, `hi_out`=1, single `div_stop` pulse, `div_zero`=0.
- Signed combinations:
  - −7/2 → `lo_out`=0xFFFFFFFD, `hi_out`=0xFFFFFFFF.
  - 7/−2 → `lo_out`=0xFFFFFFFD, `hi_out`=1.
  - −7/−2 → `lo_out`=3, `hi_out`=0xFFFFFFFF.
- Corners:
  - 0x80000000/0xFFFFFFFF → `lo_out`=0x80000000, `hi_out`=0.
  - 0/5 → 0, 0.
  - 5/7 → `lo_out`=0, `hi_out`=5.
- Divide by zero:
  - Prior result `lo_out`=3, `hi_out`=1, then start with `b`=0.
  - Require `div_stop`=`div_zero`=1 for exactly one cycle, `busy` never high, `lo_out`/`hi_out` still 3/1.
- Busy rejection and back-to-back:
  - Start 100/7, re-pulse `div_control` with 9/3 at cycle 5 → ignored; result 14/2.
  - Then start 9/3 on the cycle `div_stop` falls → result 3/0 after 33 cycles.
- Reset mid-operation:
  - Start 1000/3, assert `reset` at cycle 10 → all outputs 0, no `div_stop`.
  - Then 10/4 completes normally → `lo_out`=2, `hi_out`=2.

Source files
------------

// File: rtl/div_unit.sv
// Sequential signed divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per cycle, then a sign-fix cycle (MIPS div semantics).
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             div_stop,
  output logic             div_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;

  logic             b_zero;
  logic             start_ok;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] rem_lo;

  assign b_zero   = (b == '0);
  assign start_ok = div_control && !b_zero;
  // Magnitude of the most negative value wraps to itself, which is the
  // correct unsigned magnitude.
  assign abs_a    = a[WIDTH-1] ? -a : a;
  assign abs_b    = b[WIDTH-1] ? -b : b;
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign trial    = rem_sh - {2'b00, dvs};
  assign rem_lo   = rem[WIDTH-1:0];

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = CALC;
      CALC:    if (count == LAST_ITER) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      lo_out   <= '0;
      hi_out   <= '0;
      div_stop <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      div_stop <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          busy  <= start_ok;
          if (div_control && b_zero) begin
            div_stop <= 1'b1;
            div_zero <= 1'b1;
          end
        end
        CALC: count <= count + 1'b1;
        FIX: begin
          // busy stays high through the cycle in which div_stop is visible.
          lo_out   <= neg_q ? -quo : quo;
          hi_out   <= neg_r ? -rem_lo : rem_lo;
          div_stop <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the datapath registers are deliberately not reset; they are always
  // loaded on start before they can influence any output.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (start_ok) begin
        quo   <= abs_a;
        dvs   <= abs_b;
        rem   <= '0;
        neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
        neg_r <= a[WIDTH-1];
      end
    end else if (state == CALC) begin
      if (!trial[WIDTH+1]) begin
        rem <= trial[WIDTH:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= rem_sh[WIDTH:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corners plus random operands
// checked against a plain signed-arithmetic reference.
module tb_div_unit;

  localparam int WIDTH   = 32;
  localparam int LATENCY = WIDTH + 1;

  logic             clk;
  logic             reset;
  logic             div_control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] lo_out;
  logic [WIDTH-1:0] hi_out;
  logic             div_stop;
  logic             div_zero;
  logic             busy;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .div_control(div_control),
    .a          (a),
    .b          (b),
    .lo_out     (lo_out),
    .hi_out     (hi_out),
    .div_stop   (div_stop),
    .div_zero   (div_zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference: 64-bit signed arithmetic truncates toward zero and gives the
  // remainder the dividend's sign; the low 32 bits are the wrapped result.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sx, sy, tq, tr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    tq = sx / sy;
    tr = sx % sy;
    q  = tq[31:0];
    r  = tr[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a start request and returns 1 time unit after the start edge,
  // with the operand inputs scrambled to prove they were captured.
  task automatic start_div(input logic [31:0] av, input logic [31:0] bv);
    a           = av;
    b           = bv;
    div_control = 1'b1;
    tick();
    div_control = 1'b0;
    a           = $urandom;
    b           = $urandom;
  endtask

  // Counts edges until div_stop is seen (bounded), noting any edge where busy
  // was low in the meantime.
  task automatic wait_stop(output int lat, output int busy_low);
    lat      = 0;
    busy_low = 0;
    do begin
      tick();
      lat++;
      if (busy !== 1'b1) busy_low++;
    end while (div_stop !== 1'b1 && lat < 100);
  endtask

  task automatic run_div(input logic [31:0] av, input logic [31:0] bv, input string tag);
    logic [31:0] exp_lo, exp_hi;
    int lat, busy_low;
    ref_div(av, bv, exp_lo, exp_hi);
    start_div(av, bv);
    wait_stop(lat, busy_low);
    checks++;
    if (lat !== LATENCY || div_stop !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles (div_stop=%b), want %0d", tag, lat, div_stop, LATENCY);
    end
    checks++;
    if (busy_low !== 0) begin
      errors++;
      $display("FAIL %s busy: low for %0d cycles during operation, want 0", tag, busy_low);
    end
    checks++;
    if (lo_out !== exp_lo) begin
      errors++;
      $display("FAIL %s lo_out: got %h want %h", tag, lo_out, exp_lo);
    end
    checks++;
    if (hi_out !== exp_hi) begin
      errors++;
      $display("FAIL %s hi_out: got %h want %h", tag, hi_out, exp_hi);
    end
    checks++;
    if (div_zero !== 1'b0) begin
      errors++;
      $display("FAIL %s div_zero: got %b want 0", tag, div_zero);
    end
    tick();
    checks++;
    if (div_stop !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s tail: div_stop=%b busy=%b, want 0 0", tag, div_stop, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; div_control = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    checks++;
    if ({lo_out, hi_out, div_stop, div_zero, busy} !== '0) begin
      errors++;
      $display("FAIL reset_values: lo=%h hi=%h stop=%b zero=%b busy=%b, want all 0",
               lo_out, hi_out, div_stop, div_zero, busy);
    end
    // Reset must win over a simultaneous start, including a zero divisor.
    a = 32'd7; b = 32'd2; div_control = 1'b1;
    tick();
    b = '0;
    tick();
    div_control = 1'b0;
    checks++;
    if (busy !== 1'b0 || div_stop !== 1'b0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: busy=%b stop=%b zero=%b, want 0 0 0", busy, div_stop, div_zero);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    run_div(32'd7,        32'd2,        "u7_2");
    run_div(-32'sd7,      32'd2,        "n7_2");
    run_div(32'd7,        -32'sd2,      "7_n2");
    run_div(-32'sd7,      -32'sd2,      "n7_n2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, "minint_n1");
    run_div(32'd0,        32'd5,        "0_5");
    run_div(32'd5,        32'd7,        "5_7");
    run_div(32'h8000_0000, 32'd1,       "minint_1");
    run_div(32'h7FFF_FFFF, 32'h8000_0000, "maxint_minint");
  endtask

  task automatic test_random();
    logic [31:0] av, bv;
    for (int i = 0; i < 20; i++) begin
      av = $urandom;
      case (i % 3)
        0:       bv = $urandom;
        1:       bv = $urandom_range(1, 15);
        default: bv = -$urandom_range(1, 300);
      endcase
      if (bv == '0) bv = 32'd3;
      run_div(av, bv, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_div_zero();
    run_div(32'd7, 32'd2, "pre_zero");
    start_div($urandom, 32'd0);
    checks++;
    if (div_stop !== 1'b1 || div_zero !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL div0_pulse: stop=%b zero=%b busy=%b, want 1 1 0", div_stop, div_zero, busy);
    end
    checks++;
    if (lo_out !== 32'd3 || hi_out !== 32'd1) begin
      errors++;
      $display("FAIL div0_hold: lo=%h hi=%h, want 3 1", lo_out, hi_out);
    end
    tick();
    checks++;
    if (div_stop !== 1'b0 || div_zero !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL div0_clear: stop=%b zero=%b busy=%b, want 0 0 0", div_stop, div_zero, busy);
    end
    checks++;
    if (lo_out !== 32'd3 || hi_out !== 32'd1) begin
      errors++;
      $display("FAIL div0_hold_after: lo=%h hi=%h, want 3 1", lo_out, hi_out);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, lat, busy_low;
    start_div(32'd100, 32'd7);
    cyc = 0;
    repeat (4) begin tick(); cyc++; end
    a = 32'd9; b = 32'd3; div_control = 1'b1;
    tick(); cyc++;
    div_control = 1'b0;
    wait_stop(lat, busy_low);
    checks++;
    if (cyc + lat !== LATENCY) begin
      errors++;
      $display("FAIL busy_reject latency: got %0d want %0d", cyc + lat, LATENCY);
    end
    checks++;
    if (lo_out !== 32'd14 || hi_out !== 32'd2) begin
      errors++;
      $display("FAIL busy_reject result: lo=%0d hi=%0d, want 14 2", lo_out, hi_out);
    end
    // Start again on the edge where div_stop drops: the earliest legal start.
    start_div(32'd9, 32'd3);
    checks++;
    if (div_stop !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start: stop=%b busy=%b, want 0 1", div_stop, busy);
    end
    wait_stop(lat, busy_low);
    checks++;
    if (lat !== LATENCY || div_stop !== 1'b1) begin
      errors++;
      $display("FAIL b2b latency: got %0d want %0d", lat, LATENCY);
    end
    checks++;
    if (lo_out !== 32'd3 || hi_out !== 32'd0) begin
      errors++;
      $display("FAIL b2b result: lo=%0d hi=%0d, want 3 0", lo_out, hi_out);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int stops;
    start_div(32'd1000, 32'd3);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({lo_out, hi_out, div_stop, div_zero, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid: lo=%h hi=%h stop=%b zero=%b busy=%b, want all 0",
               lo_out, hi_out, div_stop, div_zero, busy);
    end
    reset = 1'b0;
    stops = 0;
    repeat (40) begin
      tick();
      if (div_stop !== 1'b0 || busy !== 1'b0) stops++;
    end
    checks++;
    if (stops !== 0) begin
      errors++;
      $display("FAIL reset_abort: %0d cycles with div_stop/busy after reset, want 0", stops);
    end
    run_div(32'd10, 32'd4, "post_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
